// File: rtl/bus_initiator.sv
// Purpose: issue one host register request onto the daisy-chained bus and match its return at the tail.
// Latency: bus_valid_o one cycle after the request handshake; read response N+2 cycles after it for an N-core chain.
// Backpressure: req_ready_o is low while a transaction is outstanding; resp_valid_o holds until resp_ready_i.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_*                          host request (addr/wdata/rw) with valid/ready handshake
//   bus_*_o                        head of the register chain (valid pulses for one cycle per issue)
//   bus_*_i                        tail of the register chain (returning transactions)
//   resp_*                         read response (data/addr/timeout flag) with valid/ready handshake
//   err_timeout_o                  one-cycle pulse whenever a read or write times out
module bus_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    input  logic        req_rw_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,

    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_wdata_o,
    output logic [15:0] bus_rdata_o,
    output logic        bus_rw_o,
    output logic        bus_valid_o,

    input  logic [15:0] bus_addr_i,
    input  logic [15:0] bus_wdata_i,
    input  logic [15:0] bus_rdata_i,
    input  logic        bus_rw_i,
    input  logic        bus_valid_i,

    output logic [15:0] resp_rdata_o,
    output logic [15:0] resp_addr_o,
    output logic        resp_timeout_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,

    output logic        err_timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter value on the last cycle a return is still accepted, and the
    // value it holds on the cycle after a timeout has been flagged.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_EXPIRED = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [15:0]          addr_q;
    logic [15:0]          wdata_q;
    logic                 rw_q;
    logic [15:0]          rdata_q, rdata_d;
    logic                 tout_q, tout_d;
    logic                 err_q, err_d;
    logic                 req_fire;
    logic                 match;

    // Write data travels through the chain untouched and plays no part in matching.
    logic unused_tail_wdata;
    assign unused_tail_wdata = ^bus_wdata_i;

    assign req_fire = (state_q == IDLE) && req_valid_i;
    assign match    = bus_valid_i && (bus_addr_i == addr_q) && (bus_rw_i == rw_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        tout_d  = tout_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_EXPIRED) begin
                    // A timed-out write lingers here one cycle after the error
                    // pulse; the acceptance window has closed, so returns are ignored.
                    state_d = IDLE;
                end else if (match) begin
                    // A match on the last accepted cycle beats the timeout.
                    if (rw_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = bus_rdata_i;
                        tout_d  = 1'b0;
                        state_d = RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                    if (!rw_q) begin
                        rdata_d = '0;
                        tout_d  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            tout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
            if (req_fire) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rw_q    <= req_rw_i;
            end
        end
    end

    // Ready is suppressed while reset is asserted so nothing is accepted then.
    assign req_ready_o    = rst_n && (state_q == IDLE);

    // The latched request doubles as the head-of-chain drive, so these hold
    // their last issued values outside ISSUE.
    assign bus_valid_o    = (state_q == ISSUE);
    assign bus_addr_o     = addr_q;
    assign bus_wdata_o    = wdata_q;
    assign bus_rw_o       = rw_q;
    assign bus_rdata_o    = '0;

    assign resp_valid_o   = (state_q == RESP);
    assign resp_rdata_o   = rdata_q;
    assign resp_addr_o    = addr_q;
    assign resp_timeout_o = tout_q;
    assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Purpose: randomized and directed checking of bus_initiator against a reference register model.
// Latency: expectations carry the exact cycle at which each bus issue, response and error must appear.
// Backpressure: resp_ready_i is randomized, and held low for a stretch in one directed test.
module tb_bus_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_addr_i, req_wdata_i;
    logic        req_rw_i, req_valid_i, req_ready_o;
    logic [15:0] bus_addr_o, bus_wdata_o, bus_rdata_o;
    logic        bus_rw_o, bus_valid_o;
    logic [15:0] bus_addr_i, bus_wdata_i, bus_rdata_i;
    logic        bus_rw_i, bus_valid_i;
    logic [15:0] resp_rdata_o, resp_addr_o;
    logic        resp_timeout_o, resp_valid_o, resp_ready_i, err_timeout_o;

    always #5 clk = ~clk;

    bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rw_i(req_rw_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_o(bus_rdata_o),
        .bus_rw_o(bus_rw_o), .bus_valid_o(bus_valid_o),
        .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_rdata_i(bus_rdata_i),
        .bus_rw_i(bus_rw_i), .bus_valid_i(bus_valid_i),
        .resp_rdata_o(resp_rdata_o), .resp_addr_o(resp_addr_o), .resp_timeout_o(resp_timeout_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .err_timeout_o(err_timeout_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- chain of cores: one register per core, shared register file
    typedef struct packed {
        logic        vld;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } btx_t;

    btx_t        pipe     [16];
    int          pipe_gen [16];
    logic [15:0] core_mem [logic [15:0]];
    int          chain_len = 3;
    bit          chain_en  = 1'b1;
    int          cur_gen   = 0;
    bit          inj_en    = 1'b0;
    btx_t        inj;
    btx_t        tail;
    btx_t        head;

    always @(posedge clk) begin
        head = '{vld: bus_valid_o, rw: bus_rw_o, addr: bus_addr_o, wdata: bus_wdata_o, rdata: bus_rdata_o};
        if (head.vld && chain_en) begin
            if (head.rw) core_mem[head.addr] = head.wdata;
            else head.rdata = core_mem.exists(head.addr) ? core_mem[head.addr] : 16'h0;
        end
        pipe[0]     <= head;
        pipe_gen[0] <= cur_gen;
        for (int i = 1; i < 16; i++) begin
            pipe[i]     <= pipe[i-1];
            pipe_gen[i] <= pipe_gen[i-1];
        end
    end

    // Only the transaction currently in flight is visible at the tail when the
    // chain length is reconfigured between requests.
    always_comb begin
        tail = '0;
        if (inj_en) tail = inj;
        else if (chain_en && pipe_gen[chain_len-1] == cur_gen) tail = pipe[chain_len-1];
    end
    assign bus_valid_i = tail.vld;
    assign bus_rw_i    = tail.rw;
    assign bus_addr_i  = tail.addr;
    assign bus_wdata_i = tail.wdata;
    assign bus_rdata_i = tail.rdata;

    // ---------------- reference model and scoreboard queues
    typedef struct { int cyc; logic [15:0] addr; logic [15:0] wdata; logic rw; } iss_t;
    typedef struct { int cyc; logic [15:0] addr; logic [15:0] rdata; logic tout; } rsp_t;

    logic [15:0] ref_mem [logic [15:0]];
    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   err_q[$];

    bit bp_hold  = 1'b0;
    bit bp_force = 1'b0;

    initial begin
        resp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold) resp_ready_i = 1'b0;
            else if (bp_force) resp_ready_i = 1'b1;
            else resp_ready_i = ($urandom_range(0, 2) != 0);
        end
    end

    // Waits for ready, configures the chain, performs one request handshake and
    // (when model is set) records what the spec rules say must follow.
    task automatic do_req(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                          input bit model, input bit en, input int len, output int t);
        int  n = 0;
        bit  hit;
        int  exp_rdy;
        logic [15:0] d;
        @(negedge clk);
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            check("req_ready_wait", 32'(req_ready_o), 32'd1);
            t = cyc;
            return;
        end
        chain_en    = en;
        chain_len   = len;
        cur_gen++;
        req_rw_i    = rw;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_valid_i = 1'b1;
        t = cyc;
        iss_q.push_back('{t + 1, addr, wdata, rw});
        hit = en && (len <= TO);
        if (model) begin
            if (!rw) begin
                d = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0;
                if (hit) rsp_q.push_back('{t + 2 + len, addr, d, 1'b0});
                else begin
                    rsp_q.push_back('{t + 2 + TO, addr, 16'h0, 1'b1});
                    err_q.push_back(t + 2 + TO);
                end
            end else begin
                if (en) ref_mem[addr] = wdata;
                if (!hit) err_q.push_back(t + 2 + TO);
            end
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = 16'($urandom);
        req_wdata_i = 16'($urandom);
        if (model && rw) begin
            exp_rdy = hit ? t + 2 + len : t + 3 + TO;
            n = 0;
            @(negedge clk);
            while (!req_ready_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("wr_ready_cycle", 32'(cyc), 32'(exp_rdy));
        end
    endtask

    // ---------------- monitor
    initial begin
        bit   prev_v = 1'b0;
        bit   acc    = 1'b0;
        rsp_t cur;
        iss_t is;
        int   ec;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus_valid_o) begin
                    if (iss_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
                    else begin
                        is = iss_q.pop_front();
                        check("issue_cycle", 32'(cyc), 32'(is.cyc));
                        check("issue_addr", {16'h0, bus_addr_o}, {16'h0, is.addr});
                        check("issue_wdata", {16'h0, bus_wdata_o}, {16'h0, is.wdata});
                        check("issue_rw_rdata", {15'h0, bus_rw_o, bus_rdata_o}, {15'h0, is.rw, 16'h0});
                    end
                end
                if (err_timeout_o) begin
                    if (err_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
                    else begin
                        ec = err_q.pop_front();
                        check("err_cycle", 32'(cyc), 32'(ec));
                    end
                end
                if (acc) begin
                    check("idle_after_accept", {30'h0, req_ready_o, resp_valid_o}, 32'b10);
                    acc    = 1'b0;
                    prev_v = 1'b0;
                end else if (resp_valid_o) begin
                    if (!prev_v) begin
                        if (rsp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
                        else begin
                            cur = rsp_q.pop_front();
                            check("resp_cycle", 32'(cyc), 32'(cur.cyc));
                            check("resp_rdata", {16'h0, resp_rdata_o}, {16'h0, cur.rdata});
                            check("resp_addr", {16'h0, resp_addr_o}, {16'h0, cur.addr});
                            check("resp_timeout", 32'(resp_timeout_o), 32'(cur.tout));
                        end
                    end else begin
                        check("resp_hold", {resp_rdata_o, resp_addr_o}, {cur.rdata, cur.addr});
                        check("resp_hold_to_rdy", {30'h0, resp_timeout_o, req_ready_o}, {30'h0, cur.tout, 1'b0});
                    end
                    prev_v = 1'b1;
                    if (resp_ready_i) acc = 1'b1;
                end else begin
                    prev_v = 1'b0;
                end
            end else begin
                prev_v = 1'b0;
                acc    = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
        check({tag, "_bus_ctl"}, {29'h0, bus_valid_o, bus_rw_o, err_timeout_o}, 32'd0);
        check({tag, "_bus_addr_wdata"}, {bus_addr_o, bus_wdata_o}, 32'd0);
        check({tag, "_bus_rdata"}, {16'h0, bus_rdata_o}, 32'd0);
        check({tag, "_resp_data_addr"}, {resp_rdata_o, resp_addr_o}, 32'd0);
        check({tag, "_resp_ctl"}, {30'h0, resp_valid_o, resp_timeout_o}, 32'd0);
    endtask

    task automatic wait_resp_valid(input logic level, input string name);
        int n = 0;
        while (resp_valid_o !== level && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(resp_valid_o), 32'(level));
    endtask

    // ---------------- stimulus
    initial begin
        int t;
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_rw_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        inj         = '0;
        core_mem[16'h0001] = 16'hBEEF;
        ref_mem[16'h0001]  = 16'hBEEF;

        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(req_ready_o), 32'd0);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset");

        // Read and write through a 3-core chain.
        do_req(1'b0, 16'h0001, 16'h0000, 1'b1, 1'b1, 3, t);
        do_req(1'b1, 16'h0002, 16'h1234, 1'b1, 1'b1, 3, t);

        // Tail tied off: read then write time out.
        do_req(1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 3, t);
        do_req(1'b1, 16'h0004, 16'h5555, 1'b1, 1'b0, 3, t);

        // Window edges: return on the last accepted cycle, then one cycle late.
        do_req(1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1, TO, t);
        do_req(1'b1, 16'h0003, 16'h7777, 1'b1, 1'b1, TO, t);
        do_req(1'b0, 16'h0003, 16'h0000, 1'b1, 1'b1, TO + 1, t);
        do_req(1'b0, 16'h0003, 16'h0000, 1'b1, 1'b1, 1, t);

        // Backpressure on the response.
        do_req(1'b0, 16'h0002, 16'h0000, 1'b1, 1'b1, 3, t);
        bp_hold = 1'b1;
        wait_resp_valid(1'b1, "bp_resp_arrives");
        repeat (20) @(negedge clk);
        bp_hold  = 1'b0;
        bp_force = 1'b1;
        wait_resp_valid(1'b0, "bp_resp_released");
        bp_force = 1'b0;

        // Non-matching returns are ignored, the true return completes the read.
        do_req(1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 3, t);
        repeat (2) @(negedge clk);
        inj    = '{vld: 1'b1, rw: 1'b0, addr: 16'h0009, wdata: 16'h0, rdata: 16'h1111};
        inj_en = 1'b1;
        @(negedge clk);
        inj    = '{vld: 1'b1, rw: 1'b1, addr: 16'h0005, wdata: 16'h0, rdata: 16'h2222};
        @(negedge clk);
        inj    = '{vld: 1'b1, rw: 1'b0, addr: 16'h0005, wdata: 16'h0, rdata: 16'h5A5A};
        rsp_q.push_back('{cyc + 1, 16'h0005, 16'h5A5A, 1'b0});
        @(negedge clk);
        inj_en = 1'b0;

        // Reset while waiting; the late return must be ignored.
        do_req(1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 3, t);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("midwait_reset");
        inj    = '{vld: 1'b1, rw: 1'b0, addr: 16'h0003, wdata: 16'h0, rdata: 16'hDEAD};
        inj_en = 1'b1;
        @(negedge clk);
        inj_en = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b0, 16'h0001, 16'h0000, 1'b1, 1'b1, 3, t);

        // Randomized traffic with varying chain lengths and broken chains.
        for (int k = 0; k < 40; k++) begin
            do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom), 1'b1,
                   ($urandom_range(0, 7) != 0), $urandom_range(1, TO + 2), t);
        end

        begin
            int n = 0;
            while ((rsp_q.size() != 0 || err_q.size() != 0 || iss_q.size() != 0) && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (4) @(negedge clk);
        check("pending_resp", 32'(rsp_q.size()), 32'd0);
        check("pending_err", 32'(err_q.size()), 32'd0);
        check("pending_issue", 32'(iss_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Drives the head of the daisy-chained register bus (addr/wdata/rdata/rw/valid, one register stage per core) and terminates its tail. Accepts one host request at a time, issues it as a single-cycle bus transaction, waits for the same transaction to emerge from the last core, and returns read data to the host with a response handshake. It sits between the host-side packet decoder and the first core; a timeout guards against a broken or misconfigured chain.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles after issue during which a returning transaction is accepted; must be ≥ 1.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1): timeout counter width; derived, do not override.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_addr_i  in  16  request address.
- req_wdata_i  in  16  request write data; ignored for reads.
- req_rw_i  in  1  1 = write, 0 = read.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted on a cycle where req_valid_i && req_ready_o.
- bus_addr_o, bus_wdata_o, bus_rdata_o  out  16 each  head of chain.
- bus_rw_o, bus_valid_o  out  1 each  head of chain.
- bus_addr_i, bus_wdata_i, bus_rdata_i  in  16 each  tail of chain.
- bus_rw_i, bus_valid_i  in  1 each  tail of chain.
- resp_rdata_o  out  16  read data, or 0 on timeout.
- resp_addr_o  out  16  address of the completed read.
- resp_timeout_o  out  1  qualifies resp_valid_o: the response is a timeout.
- resp_valid_o  out  1  read response present; held until accepted.
- resp_ready_i  in  1  host accepts the response.
- err_timeout_o  out  1  one-cycle pulse on any timeout, read or write.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready_o = 1 (combinational, state == IDLE). On handshake, latch addr/wdata/rw and go to ISSUE.
- ISSUE: bus_valid_o = 1 for exactly this cycle. bus_addr_o/bus_wdata_o/bus_rw_o carry the latched values. bus_rdata_o = 0. For reads, bus_wdata_o = latched wdata (don't-care). Clear the counter, then go to WAIT.
- Outside ISSUE: bus_valid_o = 0, bus_rdata_o = 0. Other bus outputs hold their last values.
- WAIT: the counter increments each cycle. A match is bus_valid_i && bus_addr_i == latched addr && bus_rw_i == latched rw.
  - Matched read: capture bus_rdata_i and go to RESP with resp_timeout_o = 0.
  - Matched write: go to IDLE. No response is produced.
- Non-matching bus_valid_i in WAIT is ignored. bus_valid_i in IDLE, ISSUE or RESP is ignored.
- Timeout: the counter reaches TIMEOUT_CYCLES in WAIT with no match on that cycle.
  - err_timeout_o pulses for 1 cycle.
  - Read: go to RESP with resp_rdata_o = 0 and resp_timeout_o = 1.
  - Write: go to IDLE.
- Match and timeout on the same cycle: the match wins; no error.
- RESP: resp_valid_o = 1. resp_rdata_o, resp_addr_o and resp_timeout_o are stable. On resp_ready_i, go to IDLE.
- Reset (any state): state = IDLE. Counter = 0. All outputs 0, except req_ready_o = 1 once rst_n is high. A transaction returning after reset is ignored.

## Timing
- Request handshake at cycle T puts bus_valid_o high at T+1.
- A chain of N cores (N ≥ 1) returns the transaction at T+1+N.
- A read sets resp_valid_o at T+2+N. The earliest next request handshake is the cycle after resp acceptance.
- Returns are accepted on cycles T+2 through T+1+TIMEOUT_CYCLES.
- With no match, err_timeout_o is high at T+2+TIMEOUT_CYCLES. For a read, resp_valid_o also rises at T+2+TIMEOUT_CYCLES.
- Only one transaction is ever outstanding.

## Test plan
- Read, 3-core chain model (each core: 1-cycle register; the core at BASE 0 returns rdata 0xBEEF for addr 0x0001). Request read 0x0001 at T → bus_valid_o at T+1; resp_valid_o at T+5 with rdata 0xBEEF, addr 0x0001, timeout 0.
- Write 0x0002 ← 0x1234 through the same chain → bus_valid_o at T+1 with wdata 0x1234. req_ready_o returns high at T+5. No resp_valid_o, no err_timeout_o.
- Timeout, TIMEOUT_CYCLES = 8, tail tied to 0. Read at T → err_timeout_o and resp_valid_o at T+10, with rdata 0 and timeout 1. The same test as a write gives err_timeout_o only, and req_ready_o high at T+11.
- Backpressure: hold resp_ready_i = 0 for 20 cycles → response fields stable and req_ready_o = 0 throughout. Raise resp_ready_i → IDLE next cycle.
- Mismatch: in WAIT, inject bus_valid_i with addr 0x0009 → ignored. Then inject the true return → normal response.
- Reset mid-WAIT: drop rst_n for 1 cycle → all outputs 0. A late return on the tail produces no response, and a new read completes normally.
